// File: rtl/execute_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, branch/jump resolution and an
// iterative shift-add multiplier that back-pressures decode while it runs.
module execute_mc #(
    parameter int WIDTH = 16,
    parameter int RW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic             sel_lhs_imm,
    input  logic             sel_rhs_imm,
    input  logic             is_branch,
    input  logic             is_jump,
    input  logic [3:0]       cond,
    input  logic [RW-1:0]    s_1,
    input  logic [RW-1:0]    s_2,
    input  logic [RW-1:0]    tgt,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] reg_out_1,
    input  logic [WIDTH-1:0] reg_out_2,
    input  logic [RW-1:0]    mem_tgt,
    input  logic [WIDTH-1:0] mem_result,
    input  logic [RW-1:0]    wb_tgt,
    input  logic [WIDTH-1:0] wb_result,
    input  logic             flush,
    output logic             valid_out,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] store_data,
    output logic [RW-1:0]    tgt_out,
    output logic             branch,
    output logic [WIDTH-1:0] branch_tgt,
    output logic             busy
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0]       r_state;
    logic [SW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mc, r_mp, r_acc, r_mop2;
    logic [RW-1:0]    r_mtgt;
    logic             r_valid_out;
    logic [WIDTH-1:0] r_result, r_store;
    logic [RW-1:0]    r_tgt_out;

    logic [WIDTH-1:0] w_op1, w_op2, w_lhs, w_rhs, w_sum, w_alu, w_acc_next;
    logic [WIDTH:0]   w_diff;
    logic             w_z, w_n, w_c, w_o, w_taken, w_accept, w_start_mul;

    // Youngest producer wins; register 0 always reads the register file.
    function automatic logic [WIDTH-1:0] fwd(
        input logic [RW-1:0] s, input logic [WIDTH-1:0] rf,
        input logic own_v, input logic [RW-1:0] own_t, input logic [WIDTH-1:0] own_r,
        input logic [RW-1:0] m_t, input logic [WIDTH-1:0] m_r,
        input logic [RW-1:0] w_t, input logic [WIDTH-1:0] w_r);
        if (s == '0)                    return rf;
        else if (own_v && own_t == s)   return own_r;
        else if (m_t == s)              return m_r;
        else if (w_t == s)              return w_r;
        else                            return rf;
    endfunction

    assign w_op1 = fwd(s_1, reg_out_1, r_valid_out, r_tgt_out, r_result,
                       mem_tgt, mem_result, wb_tgt, wb_result);
    assign w_op2 = fwd(s_2, reg_out_2, r_valid_out, r_tgt_out, r_result,
                       mem_tgt, mem_result, wb_tgt, wb_result);
    assign w_lhs = sel_lhs_imm ? imm : w_op1;
    assign w_rhs = sel_rhs_imm ? imm : w_op2;
    assign w_sum = w_lhs + w_rhs;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_alu = '0;
        case (alu_op)
            3'd0:    w_alu = w_sum;
            3'd1:    w_alu = w_lhs - w_rhs;
            3'd2:    w_alu = w_lhs & w_rhs;
            3'd3:    w_alu = w_lhs | w_rhs;
            3'd4:    w_alu = w_lhs ^ w_rhs;
            3'd5:    w_alu = w_lhs << w_rhs[SW-1:0];
            3'd6:    w_alu = w_lhs >> w_rhs[SW-1:0];
            default: w_alu = '0;
        endcase
        if (is_branch || is_jump) w_alu = w_sum;
    end

    assign w_diff = {1'b0, w_lhs} - {1'b0, w_rhs};
    assign w_z    = (w_diff[WIDTH-1:0] == '0);
    assign w_n    = w_diff[WIDTH-1];
    assign w_c    = w_diff[WIDTH];
    assign w_o    = (w_lhs[WIDTH-1] != w_rhs[WIDTH-1]) && (w_diff[WIDTH-1] != w_lhs[WIDTH-1]);

    always_comb begin
        w_taken = 1'b0;
        case (cond)
            4'd0:    w_taken = w_z;
            4'd1:    w_taken = !w_z;
            4'd2:    w_taken = (w_n != w_o);
            4'd3:    w_taken = (w_n == w_o);
            4'd4:    w_taken = !w_z && (w_n == w_o);
            4'd5:    w_taken = w_z || (w_n != w_o);
            4'd6:    w_taken = w_c;
            4'd7:    w_taken = !w_c;
            4'd8:    w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state == S_MUL);
    assign w_accept    = valid_in && in_ready && !flush;
    assign w_start_mul = w_accept && (alu_op == 3'd7);
    assign branch      = w_accept && (is_jump || (is_branch && w_taken));
    assign branch_tgt  = is_jump                 ? w_sum :
                         (is_branch && w_taken)  ? pc_in + imm + WIDTH'(1) :
                                                   pc_in + WIDTH'(1);
    assign w_acc_next  = r_acc + (r_mp[0] ? r_mc : '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mc        <= '0;
            r_mp        <= '0;
            r_acc       <= '0;
            r_mop2      <= '0;
            r_mtgt      <= '0;
            r_valid_out <= 1'b0;
            r_result    <= '0;
            r_store     <= '0;
            r_tgt_out   <= '0;
        end else begin
            r_valid_out <= 1'b0;
            r_tgt_out   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_mul) begin
                        r_state <= S_MUL;
                        r_cnt   <= '0;
                        r_mc    <= w_lhs;
                        r_mp    <= w_rhs;
                        r_acc   <= '0;
                        r_mtgt  <= tgt;
                        r_mop2  <= w_op2;
                    end else if (w_accept) begin
                        r_result    <= w_alu;
                        r_store     <= w_op2;
                        r_tgt_out   <= tgt;
                        r_valid_out <= 1'b1;
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_mc  <= r_mc << 1;
                        r_mp  <= r_mp >> 1;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == SW'(WIDTH - 1)) begin
                            r_state     <= S_IDLE;
                            r_result    <= w_acc_next;
                            r_store     <= r_mop2;
                            r_tgt_out   <= r_mtgt;
                            r_valid_out <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign valid_out  = r_valid_out;
    assign result     = r_result;
    assign store_data = r_store;
    assign tgt_out    = r_tgt_out;
endmodule
